issueque_int: RTL and testbench
===============================

// Module: issueque_int
// PURPOSE
//  Integer issue queue feeding the integer execution port of the issue unit.
//  Holds up to DEPTH dispatched integer ops and snoops the CDB to capture pending source operands.
//  Each cycle it presents the oldest op whose operands are both ready on issueint_*.
//  The entry is removed when the issue unit answers with issueint_equeueint_done.
// PARAMETERS
//  DEPTH  4  number of queue entries; 2..8 supported
//  CNTW   3  width of the occupancy counter; must be >= clog2(DEPTH+1)
// PORTS
//  clk                      in   1   clock, rising edge
//  reset                    in   1   asynchronous, active-low reset
//  flush                    in   1   sync clear of all entries (mispredict recovery)
//  dispatch_en              in   1   write one new op this cycle
//  dispatch_opcode          in   4   ALU opcode
//  dispatch_rdtag           in   6   destination tag
//  dispatch_rsdata          in   32  rs value (meaningful when rsvalid=1)
//  dispatch_rstag           in   6   rs producer tag (meaningful when rsvalid=0)
//  dispatch_rsvalid         in   1   rs value already available
//  dispatch_rtdata/rttag/rtvalid  in  32/6/1  same for rt
//  cdb_valid                in   1   CDB broadcast valid
//  cdb_tagout               in   6   CDB tag
//  cdb_out                  in   32  CDB data
//  issueint_equeueint_done  in   1   issue unit consumed the presented op
//  issueque_full            out  1   count==DEPTH, registered
//  issueque_count           out  CNTW  number of valid entries
//  issueint_ready           out  1   a ready op is presented
//  issueint_opcode/rsdata/rtdata/rdtag  out  4/32/32/6  presented op
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All entries invalid; count=0; full=0; ready=0.
//   - opcode/rsdata/rtdata/rdtag outputs = 0.
//  Storage and ordering:
//   - Entries are kept age-ordered; slot 0 is the oldest.
//   - Each entry holds valid, opcode, rdtag, and {data, tag, rdy} for both rs and rt.
//  Selection (combinational from registered state only):
//   - Pick the lowest index i with valid & rsrdy & rtrdy.
//   - issueint_ready=1 and outputs = entry i; when no entry qualifies, ready=0 and outputs=0.
//   - No CDB or done input may reach ready/outputs combinationally. The issue unit derives
//     done and cdb_valid from ready in the same cycle, so such a path would form a loop.
//  Issue:
//   - done is sampled only when ready=1; done with ready=0 is ignored.
//   - On the clock edge, selected entry i is removed.
//   - Entries i+1..count-1 shift down one slot, preserving age order.
//  Dispatch:
//   - Accepted only when dispatch_en & ~issueque_full (full taken from the start of the cycle).
//   - dispatch_en while full is dropped with no state change.
//   - The new op is written at slot count, or count-1 if an issue occurs in the same cycle.
//   - Net count: +1 dispatch only, -1 issue only, unchanged when both occur.
//  Wakeup (one cycle):
//   - When cdb_valid and an entry's operand has rdy=0 and tag==cdb_tagout,
//     set data=cdb_out and rdy=1 at the clock edge.
//   - Applies to every valid entry, including entries shifting this cycle (captured in the new slot).
//   - Bypass into dispatch: if the dispatched operand has rsvalid/rtvalid=0 and its tag matches
//     the current CDB, it is written with rdy=1 and data=cdb_out.
//   - A woken entry is first eligible for selection the cycle after the broadcast.
//   - The entry being removed by issue ignores wakeup.
//  Flush: clears all valid bits and count next edge, overriding dispatch, issue and wakeup that cycle.
//  issueque_full/count are registered and reflect post-edge state.
// TESTING
//  1. Reset=0 mid-op with 3 entries -> ready=0, count=0, full=0 asynchronously.
//     After release, dispatch 0x5+0x7 (rdtag=6'h03) -> next cycle ready=1, rsdata=5, rtdata=7, rdtag=3.
//  2. Dispatch A (rs tag 6'h10 pending), then B (ready) -> B presented first.
//     CDB tag 10 data 0xDEAD -> A eligible one cycle later with rsdata=0xDEAD.
//  3. Fill to DEPTH=4 -> full=1; a 5th dispatch_en is dropped.
//     Issue+dispatch in the same cycle while count=3 -> count stays 3, order kept.
//  4. Entries 0..3 ready, done on slot 0 -> slots 1..3 shift down.
//     Next presented rdtag = old slot 1; done held low -> same op presented repeatedly.
//  5. Dispatch with rstag=6'h22 while CDB broadcasts tag 22 data 0x1234 -> entry stored ready, rsdata=0x1234.
//  6. flush with dispatch_en and done asserted -> count=0, ready=0 next cycle.

Source files
------------

// File: rtl/issueque_int.sv
// -----------------------------------------------------------------------------
// issueque_int
// Integer issue queue in front of the integer execution port. It holds up to
// DEPTH dispatched ops in age order, with slot 0 the oldest. It snoops the CDB
// to wake pending source operands. Every cycle it presents the oldest op whose
// two operands are ready. The op leaves the queue when the issue unit answers
// with issueint_equeueint_done.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   flush                       synchronous clear of every entry
//   dispatch_*                  one new op per cycle (dropped while full)
//   cdb_valid/tagout/out        result broadcast used for operand wakeup
//   issueint_equeueint_done     issue unit consumed the presented op
//   issueque_full/count         registered occupancy state
//   issueint_ready/opcode/rsdata/rtdata/rdtag   presented op
// -----------------------------------------------------------------------------
module issueque_int #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            dispatch_en,
    input  logic [3:0]      dispatch_opcode,
    input  logic [5:0]      dispatch_rdtag,
    input  logic [31:0]     dispatch_rsdata,
    input  logic [5:0]      dispatch_rstag,
    input  logic            dispatch_rsvalid,
    input  logic [31:0]     dispatch_rtdata,
    input  logic [5:0]      dispatch_rttag,
    input  logic            dispatch_rtvalid,
    input  logic            cdb_valid,
    input  logic [5:0]      cdb_tagout,
    input  logic [31:0]     cdb_out,
    input  logic            issueint_equeueint_done,
    output logic            issueque_full,
    output logic [CNTW-1:0] issueque_count,
    output logic            issueint_ready,
    output logic [3:0]      issueint_opcode,
    output logic [31:0]     issueint_rsdata,
    output logic [31:0]     issueint_rtdata,
    output logic [5:0]      issueint_rdtag
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [5:0]  rdtag;
        logic [31:0] rsdata;
        logic [5:0]  rstag;
        logic        rsrdy;
        logic [31:0] rtdata;
        logic [5:0]  rttag;
        logic        rtrdy;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic            full_q;
    logic            full_d;

    logic            sel_found_s;
    logic [IDXW-1:0] sel_idx_s;
    logic            issue_s;
    logic            accept_s;
    logic [CNTW-1:0] wr_idx_s;
    entry_t          new_entry_s;

    // Capture the CDB result into any valid operand that is still waiting on it.
    function automatic entry_t wake(input entry_t e, input logic cv,
                                    input logic [5:0] ct, input logic [31:0] cd);
        entry_t r;
        r = e;
        if (cv && e.valid && !e.rsrdy && (e.rstag == ct)) begin
            r.rsdata = cd;
            r.rsrdy  = 1'b1;
        end else begin
            r.rsrdy  = e.rsrdy;
        end
        if (cv && e.valid && !e.rtrdy && (e.rttag == ct)) begin
            r.rtdata = cd;
            r.rtrdy  = 1'b1;
        end else begin
            r.rtrdy  = e.rtrdy;
        end
        return r;
    endfunction

    // Oldest-first pick of a fully ready entry, using registered state only.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_q[i].valid && entry_q[i].rsrdy && entry_q[i].rtrdy) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDXW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Present the selected entry. With nothing selected, all outputs read zero.
    always_comb begin
        issueint_ready  = sel_found_s;
        if (sel_found_s) begin
            issueint_opcode = entry_q[sel_idx_s].opcode;
            issueint_rsdata = entry_q[sel_idx_s].rsdata;
            issueint_rtdata = entry_q[sel_idx_s].rtdata;
            issueint_rdtag  = entry_q[sel_idx_s].rdtag;
        end else begin
            issueint_opcode = 4'h0;
            issueint_rsdata = 32'h0;
            issueint_rtdata = 32'h0;
            issueint_rdtag  = 6'h00;
        end
    end

    // Build the dispatched entry, bypassing a CDB result that arrives in the same cycle.
    always_comb begin
        new_entry_s        = '0;
        new_entry_s.valid  = 1'b1;
        new_entry_s.opcode = dispatch_opcode;
        new_entry_s.rdtag  = dispatch_rdtag;
        new_entry_s.rstag  = dispatch_rstag;
        new_entry_s.rttag  = dispatch_rttag;
        if (!dispatch_rsvalid && cdb_valid && (dispatch_rstag == cdb_tagout)) begin
            new_entry_s.rsdata = cdb_out;
            new_entry_s.rsrdy  = 1'b1;
        end else begin
            new_entry_s.rsdata = dispatch_rsdata;
            new_entry_s.rsrdy  = dispatch_rsvalid;
        end
        if (!dispatch_rtvalid && cdb_valid && (dispatch_rttag == cdb_tagout)) begin
            new_entry_s.rtdata = cdb_out;
            new_entry_s.rtrdy  = 1'b1;
        end else begin
            new_entry_s.rtdata = dispatch_rtdata;
            new_entry_s.rtrdy  = dispatch_rtvalid;
        end
    end

    // Handshake decode. Done counts only while an op is presented, and full
    // is the value held at the start of the cycle.
    always_comb begin
        issue_s  = sel_found_s & issueint_equeueint_done;
        accept_s = dispatch_en & ~full_q;
        if (issue_s) begin
            wr_idx_s = count_q - CNTW'(1);
        end else begin
            wr_idx_s = count_q;
        end
    end

    // Next queue contents: compact over the issued slot, apply wakeup,
    // append the dispatched op, and let flush override everything.
    always_comb begin
        int src;
        src = 0;
        for (int j = 0; j < DEPTH; j++) begin
            if (issue_s && (j >= int'(sel_idx_s))) begin
                src = j + 1;
            end else begin
                src = j;
            end
            if (src < DEPTH) begin
                entry_d[j] = wake(entry_q[IDXW'(src)], cdb_valid, cdb_tagout, cdb_out);
            end else begin
                entry_d[j] = '0;
            end
            if (accept_s && (j == int'(wr_idx_s))) begin
                entry_d[j] = new_entry_s;
            end else begin
                entry_d[j] = entry_d[j];
            end
            if (flush) begin
                entry_d[j] = '0;
            end else begin
                entry_d[j] = entry_d[j];
            end
        end
    end

    // Occupancy bookkeeping. Issue and dispatch in the same cycle cancel out.
    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNTW'(accept_s) - CNTW'(issue_s);
        end
        full_d = (count_d == CNTW'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= entry_d[k];
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign issueque_full  = full_q;
    assign issueque_count = count_q;

endmodule

// File: tb/tb_issueque_int.sv
module tb_issueque_int;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rdtag;
    logic [31:0] dispatch_rsdata;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rsvalid;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rtvalid;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        issueint_equeueint_done;
    logic        issueque_full;
    logic [2:0]  issueque_count;
    logic        issueint_ready;
    logic [3:0]  issueint_opcode;
    logic [31:0] issueint_rsdata;
    logic [31:0] issueint_rtdata;
    logic [5:0]  issueint_rdtag;

    int n_total = 0;
    int n_pass  = 0;

    issueque_int #(.DEPTH(4), .CNTW(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_rsdata(dispatch_rsdata),
        .dispatch_rstag(dispatch_rstag), .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rtdata(dispatch_rtdata), .dispatch_rttag(dispatch_rttag),
        .dispatch_rtvalid(dispatch_rtvalid), .cdb_valid(cdb_valid),
        .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .issueint_equeueint_done(issueint_equeueint_done),
        .issueque_full(issueque_full), .issueque_count(issueque_count),
        .issueint_ready(issueint_ready), .issueint_opcode(issueint_opcode),
        .issueint_rsdata(issueint_rsdata), .issueint_rtdata(issueint_rtdata),
        .issueint_rdtag(issueint_rdtag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] rsd;
        logic        rsv;
        logic [5:0]  rst;
        logic [31:0] rtd;
        logic        rtv;
        logic [5:0]  rtt;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        done;
        logic        fl;
        logic        e_rdy;
        logic [3:0]  e_op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [5:0]  e_rd;
        logic [2:0]  e_cnt;
        logic        e_full;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dispatch_en             = v.en;
        dispatch_opcode         = v.op;
        dispatch_rdtag          = v.rd;
        dispatch_rsdata         = v.rsd;
        dispatch_rsvalid        = v.rsv;
        dispatch_rstag          = v.rst;
        dispatch_rtdata         = v.rtd;
        dispatch_rtvalid        = v.rtv;
        dispatch_rttag          = v.rtt;
        cdb_valid               = v.cv;
        cdb_tagout              = v.ct;
        cdb_out                 = v.cd;
        issueint_equeueint_done = v.done;
        flush                   = v.fl;
    endtask

    task automatic idle();
        vec_t z;
        z = '0;
        drive(z);
    endtask

    task automatic disp_ready(input logic [3:0] op, input logic [5:0] rd,
                              input logic [31:0] rs, input logic [31:0] rt);
        vec_t z;
        z = '0;
        z.en = 1'b1; z.op = op; z.rd = rd;
        z.rsd = rs; z.rsv = 1'b1; z.rtd = rt; z.rtv = 1'b1;
        drive(z);
    endtask

    initial begin
        // Field order: en op rd rsd rsv rst rtd rtv rtt cv ct cd done fl |
        //              e_rdy e_op e_rs e_rt e_rd e_cnt e_full
        // basic op 5 + 7, then issue it
        vecs[0]  = '{1'b1, 4'h1, 6'h03, 32'h5, 1'b1, 6'h00, 32'h7, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h1, 32'h5, 32'h7, 6'h03, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd0, 1'b0};
        // A waits on tag 10, B is ready and goes first; CDB wakes A
        vecs[2]  = '{1'b1, 4'h2, 6'h0A, 32'h0, 1'b0, 6'h10, 32'h11, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 4'h3, 6'h0B, 32'h20, 1'b1, 6'h00, 32'h21, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h3, 32'h20, 32'h21, 6'h0B, 3'd2, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b1, 6'h10, 32'hDEAD, 1'b0, 1'b0,
                     1'b1, 4'h2, 32'hDEAD, 32'h11, 6'h0A, 3'd2, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b1, 4'h3, 32'h20, 32'h21, 6'h0B, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd0, 1'b0};
        // fill to four entries, fifth dispatch dropped
        vecs[7]  = '{1'b1, 4'h4, 6'h21, 32'h1, 1'b1, 6'h00, 32'h2, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h4, 32'h1, 32'h2, 6'h21, 3'd1, 1'b0};
        vecs[8]  = '{1'b1, 4'h5, 6'h22, 32'h3, 1'b1, 6'h00, 32'h4, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h4, 32'h1, 32'h2, 6'h21, 3'd2, 1'b0};
        vecs[9]  = '{1'b1, 4'h6, 6'h23, 32'h5, 1'b1, 6'h00, 32'h6, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h4, 32'h1, 32'h2, 6'h21, 3'd3, 1'b0};
        vecs[10] = '{1'b1, 4'h7, 6'h24, 32'h7, 1'b1, 6'h00, 32'h8, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h4, 32'h1, 32'h2, 6'h21, 3'd4, 1'b1};
        vecs[11] = '{1'b1, 4'h8, 6'h25, 32'h9, 1'b1, 6'h00, 32'h9, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h4, 32'h1, 32'h2, 6'h21, 3'd4, 1'b1};
        // issue slot 0, then hold done low
        vecs[12] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b1, 4'h5, 32'h3, 32'h4, 6'h22, 3'd3, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h5, 32'h3, 32'h4, 6'h22, 3'd3, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'h5, 32'h3, 32'h4, 6'h22, 3'd3, 1'b0};
        // issue + dispatch at count 3, then drain in age order
        vecs[15] = '{1'b1, 4'h9, 6'h26, 32'hA, 1'b1, 6'h00, 32'hB, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b1, 4'h6, 32'h5, 32'h6, 6'h23, 3'd3, 1'b0};
        vecs[16] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b1, 4'h7, 32'h7, 32'h8, 6'h24, 3'd2, 1'b0};
        vecs[17] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b1, 4'h9, 32'hA, 32'hB, 6'h26, 3'd1, 1'b0};
        vecs[18] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd0, 1'b0};
        // dispatch bypass from the live CDB
        vecs[19] = '{1'b1, 4'hA, 6'h30, 32'hFFFF, 1'b0, 6'h22, 32'h55, 1'b1, 6'h00, 1'b1, 6'h22, 32'h1234, 1'b0, 1'b0,
                     1'b1, 4'hA, 32'h1234, 32'h55, 6'h30, 3'd1, 1'b0};
        // issue + dispatch, tag mismatch: no bypass
        vecs[20] = '{1'b1, 4'hB, 6'h31, 32'h40, 1'b1, 6'h00, 32'h0, 1'b0, 6'h33, 1'b1, 6'h34, 32'h99, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd1, 1'b0};
        vecs[21] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b1, 6'h33, 32'h77, 1'b0, 1'b0,
                     1'b1, 4'hB, 32'h40, 32'h77, 6'h31, 3'd1, 1'b0};
        vecs[22] = '{1'b1, 4'hC, 6'h32, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b1, 4'hB, 32'h40, 32'h77, 6'h31, 3'd2, 1'b0};
        // flush overrides dispatch and done
        vecs[23] = '{1'b1, 4'hD, 6'h33, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b1,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd0, 1'b0};
        vecs[24] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd0, 1'b0};
        // done with ready low is ignored
        vecs[25] = '{1'b1, 4'hE, 6'h35, 32'h0, 1'b0, 6'h3F, 32'h2, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd1, 1'b0};
        vecs[26] = '{1'b0, 4'h0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0,
                     1'b0, 4'h0, 32'h0, 32'h0, 6'h00, 3'd1, 1'b0};

        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", -1, 32'(issueint_ready), 32'h0);
        check("rst_count", -1, 32'(issueque_count), 32'h0);
        reset = 1'b1;

        // Three entries in flight, then an asynchronous reset mid-cycle
        disp_ready(4'h1, 6'h01, 32'h1, 32'h1);
        @(posedge clk); #1;
        disp_ready(4'h2, 6'h02, 32'h2, 32'h2);
        @(posedge clk); #1;
        disp_ready(4'h3, 6'h03, 32'h3, 32'h3);
        @(posedge clk); #1;
        idle();
        check("pre_rst_count", -1, 32'(issueque_count), 32'h3);
        check("pre_rst_ready", -1, 32'(issueint_ready), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_ready", -1, 32'(issueint_ready), 32'h0);
        check("async_count", -1, 32'(issueque_count), 32'h0);
        check("async_full", -1, 32'(issueque_full), 32'h0);
        check("async_opcode", -1, 32'(issueint_opcode), 32'h0);
        check("async_rsdata", -1, issueint_rsdata, 32'h0);
        check("async_rdtag", -1, 32'(issueint_rdtag), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check("ready", i, 32'(issueint_ready), 32'(vecs[i].e_rdy));
            check("opcode", i, 32'(issueint_opcode), 32'(vecs[i].e_op));
            check("rsdata", i, issueint_rsdata, vecs[i].e_rs);
            check("rtdata", i, issueint_rtdata, vecs[i].e_rt);
            check("rdtag", i, 32'(issueint_rdtag), 32'(vecs[i].e_rd));
            check("count", i, 32'(issueque_count), 32'(vecs[i].e_cnt));
            check("full", i, 32'(issueque_full), 32'(vecs[i].e_full));
        end
        idle();
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
